// File: rtl/cla_gpk_adder16.sv
// Registered 16-bit unsigned adder: GPK-encoded Kogge-Stone carry-lookahead core
// feeding a single output register stage (sum[16] is the carry-out).
module cla_gpk_adder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] sum,
  output logic        out_valid
);

  localparam int DATA_W = 16;
  localparam int LEVELS = 4;

  localparam logic [1:0] ST_K = 2'b00;
  localparam logic [1:0] ST_P = 2'b01;
  localparam logic [1:0] ST_G = 2'b10;

  // hi o lo: a propagating upper span passes the lower span's status through.
  function automatic logic [1:0] gpk_combine(input logic [1:0] hi, input logic [1:0] lo);
    return (hi == ST_P) ? lo : hi;
  endfunction

  function automatic logic [1:0] gpk_encode(input logic ai, input logic bi);
    if (ai && bi)
      return ST_G;
    else if (ai ^ bi)
      return ST_P;
    else
      return ST_K;
  endfunction

  logic [1:0]        pfx [LEVELS+1][DATA_W];
  logic [DATA_W-1:0] carry;
  logic [DATA_W:0]   sum_p0;
  logic [DATA_W:0]   sum_p1;
  logic              vld_p1;

  // Stage p0: combinational GPK prefix tree and sum formation
  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      pfx[0][i] = gpk_encode(a[i], b[i]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (i >= (1 << l))
          pfx[l+1][i] = gpk_combine(pfx[l][i], pfx[l][i - (1 << l)]);
        else
          pfx[l+1][i] = pfx[l][i];
      end
    end
    // Carry-in is zero, so a fully propagating prefix resolves to no carry.
    carry[0] = 1'b0;
    for (int i = 1; i < DATA_W; i++) begin
      carry[i] = (pfx[LEVELS][i-1] == ST_G);
    end
    sum_p0 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum_p0[i] = a[i] ^ b[i] ^ carry[i];
    end
    sum_p0[DATA_W] = (pfx[LEVELS][DATA_W-1] == ST_G);
  end

  // Stage p1: output register; sum holds when no valid pair arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid)
        sum_p1 <= sum_p0;
    end
  end

  assign sum       = sum_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_cla_gpk_adder16.sv
// Directed and random checks of cla_gpk_adder16 using immediate assertions.
module tb_cla_gpk_adder16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [16:0] sum;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_sum;
  logic        exp_vld;

  cla_gpk_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk_sum(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s sum observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vld(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sum = '0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = v;
      if (v)
        exp_sum = {1'b0, x} + {1'b0, y};
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    exp_sum  = '0;
    exp_vld  = 1'b0;
    @(negedge clk);

    // Reset held with valid all-ones operands
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    chk_sum("reset0", sum, 17'd0);
    chk_vld("reset0", out_valid, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    chk_sum("reset1", sum, 17'd0);
    chk_vld("reset1", out_valid, 1'b0);

    // Basic back-to-back adds
    step(1'b0, 1'b1, 16'd8193, 16'd4097);
    chk_sum("add_8193_4097", sum, 17'd12290);
    chk_vld("add_8193_4097", out_valid, 1'b1);
    step(1'b0, 1'b1, 16'd2, 16'd2);
    chk_sum("add_2_2", sum, 17'd4);
    chk_vld("add_2_2", out_valid, 1'b1);
    step(1'b0, 1'b1, 16'd6, 16'd2);
    chk_sum("add_6_2", sum, 17'd8);
    chk_vld("add_6_2", out_valid, 1'b1);

    // Full-length carry cases
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001);
    chk_sum("ffff_0001", sum, 17'h10000);
    chk_vld("ffff_0001", out_valid, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    chk_sum("ffff_ffff", sum, 17'h1FFFE);
    chk_vld("ffff_ffff", out_valid, 1'b1);
    step(1'b0, 1'b1, 16'hAAAA, 16'h5555);
    chk_sum("aaaa_5555", sum, 17'h0FFFF);
    chk_vld("aaaa_5555", out_valid, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h8000);
    chk_sum("msb_carry", sum, 17'h10000);
    chk_vld("msb_carry", out_valid, 1'b1);

    // Hold while in_valid is low
    step(1'b0, 1'b1, 16'd100, 16'd23);
    chk_sum("hold_load", sum, 17'd123);
    chk_vld("hold_load", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
      chk_sum("hold", sum, 17'd123);
      chk_vld("hold", out_valid, 1'b0);
    end

    // Mid-stream reset
    step(1'b0, 1'b1, 16'h1234, 16'h4321);
    chk_sum("pre_rst", sum, 17'h05555);
    chk_vld("pre_rst", out_valid, 1'b1);
    step(1'b1, 1'b1, 16'hF00F, 16'h0FF1);
    chk_sum("mid_rst", sum, 17'd0);
    chk_vld("mid_rst", out_valid, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 16'h0001);
    chk_sum("post_rst_idle", sum, 17'd0);
    chk_vld("post_rst_idle", out_valid, 1'b0);
    step(1'b0, 1'b1, 16'hF00F, 16'h0FF1);
    chk_sum("post_rst", sum, 17'h10000);
    chk_vld("post_rst", out_valid, 1'b1);

    // Random stream with occasional resets
    for (int k = 0; k < 12000; k++) begin
      logic r;
      logic v;
      logic [15:0] x;
      logic [15:0] y;
      r = ($urandom_range(0, 199) == 0);
      v = $urandom_range(0, 3) != 0;
      x = 16'($urandom);
      y = 16'($urandom);
      step(r, v, x, y);
      chk_vld("rand", out_valid, exp_vld);
      chk_sum("rand", sum, exp_sum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
